// File: rtl/xphy_link_ctrl_if.sv
// Status and control bundle between the link bring-up sequencer (master) and the MAC/PHY side (slave).
interface xphy_link_ctrl_if;
  logic       tx_resetdone;
  logic       rx_resetdone;
  logic       signal_detect;
  logic       tx_fault;
  logic       block_lock;
  logic       restart;
  logic       phy_reset;
  logic       core_reset_tx;
  logic       core_reset_rx;
  logic       link_up;
  logic       link_fail;
  logic [7:0] retry_cnt;
  logic [2:0] ctrl_state;

  modport master (
    input  tx_resetdone, rx_resetdone, signal_detect, tx_fault, block_lock, restart,
    output phy_reset, core_reset_tx, core_reset_rx, link_up, link_fail, retry_cnt, ctrl_state
  );

  modport slave (
    output tx_resetdone, rx_resetdone, signal_detect, tx_fault, block_lock, restart,
    input  phy_reset, core_reset_tx, core_reset_rx, link_up, link_fail, retry_cnt, ctrl_state
  );
endinterface

// File: rtl/xphy_link_ctrl.sv
// 10G link bring-up sequencer: PHY reset pulse, GT/optics/lock qualification, ordered MAC reset release
// and bounded retries. All outputs are registered (one cycle from the deciding input); no backpressure.
module xphy_link_ctrl #(
  parameter int C_RST_CYCLES    = 16,
  parameter int C_WAIT_TIMEOUT  = 65535,
  parameter int C_LOCK_DEBOUNCE = 1024,
  parameter int C_RETRY_MAX     = 7
) (
  input  logic             clk156,
  input  logic             reset,
  xphy_link_ctrl_if.master lnk
);

  typedef enum logic [2:0] {
    HOLD_RST  = 3'd0,
    WAIT_DONE = 3'd1,
    WAIT_SIG  = 3'd2,
    REL_TX    = 3'd3,
    WAIT_LOCK = 3'd4,
    UP        = 3'd5,
    FAIL      = 3'd6
  } state_t;

  // Terminal values are one below the cycle counts: compare happens before increment.
  localparam logic [15:0] RST_LAST  = 16'(C_RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(C_WAIT_TIMEOUT - 1);
  localparam logic [15:0] DB_LAST   = 16'(C_LOCK_DEBOUNCE - 1);
  localparam logic [7:0]  RETRY_LIM = 8'(C_RETRY_MAX);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] lock_cnt, lock_nxt;
  logic [7:0]  retry_q, retry_nxt;
  logic        retry_evt;
  logic        done_ok;
  logic        sig_ok;

  assign done_ok = lnk.tx_resetdone & lnk.rx_resetdone;
  assign sig_ok  = lnk.signal_detect & ~lnk.tx_fault;

  // {phy_reset, core_reset_tx, core_reset_rx, link_up, link_fail}
  function automatic logic [4:0] decode(state_t s);
    logic [4:0] d;
    d = 5'b11100;
    case (s)
      HOLD_RST:  d = 5'b11100;
      WAIT_DONE: d = 5'b01100;
      WAIT_SIG:  d = 5'b01100;
      REL_TX:    d = 5'b00100;
      WAIT_LOCK: d = 5'b00000;
      UP:        d = 5'b00010;
      FAIL:      d = 5'b11101;
      default:   d = 5'b11100;
    endcase
    return d;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lock_nxt  = lock_cnt;
    retry_nxt = retry_q;
    retry_evt = 1'b0;

    if (lnk.restart) begin
      state_nxt = HOLD_RST;
      retry_nxt = 8'd0;
    end else begin
      case (state)
        HOLD_RST: begin
          if (cnt == RST_LAST) state_nxt = WAIT_DONE;
          else                 cnt_nxt   = cnt + 16'd1;
        end
        WAIT_DONE: begin
          if (done_ok)              state_nxt = WAIT_SIG;
          else if (cnt == TO_LAST)  retry_evt = 1'b1;
          else                      cnt_nxt   = cnt + 16'd1;
        end
        // Fibre may legitimately be absent, so no timeout here.
        WAIT_SIG: begin
          if (!done_ok)     state_nxt = HOLD_RST;
          else if (sig_ok)  state_nxt = REL_TX;
        end
        REL_TX: begin
          if (!done_ok)     state_nxt = HOLD_RST;
          else if (!sig_ok) state_nxt = WAIT_SIG;
          else              state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (!done_ok)                                  state_nxt = HOLD_RST;
          else if (!sig_ok)                              state_nxt = WAIT_SIG;
          else if (lnk.block_lock && lock_cnt == DB_LAST) state_nxt = UP;
          else if (cnt == TO_LAST)                       retry_evt = 1'b1;
          else begin
            cnt_nxt  = cnt + 16'd1;
            lock_nxt = lnk.block_lock ? lock_cnt + 16'd1 : 16'd0;
          end
        end
        UP: begin
          if (!done_ok)                         state_nxt = HOLD_RST;
          else if (!lnk.block_lock || !sig_ok)  state_nxt = WAIT_SIG;
        end
        FAIL:    state_nxt = FAIL;
        default: state_nxt = HOLD_RST;
      endcase

      if (retry_evt) begin
        retry_nxt = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
        state_nxt = (retry_nxt == RETRY_LIM) ? FAIL : HOLD_RST;
      end
      if (state_nxt == UP && state != UP) retry_nxt = 8'd0;
    end

    // Every phase starts its timers from zero, including a restart into HOLD_RST.
    if (lnk.restart || state_nxt != state) begin
      cnt_nxt  = 16'd0;
      lock_nxt = 16'd0;
    end
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      state             <= HOLD_RST;
      cnt               <= 16'd0;
      lock_cnt          <= 16'd0;
      retry_q           <= 8'd0;
      lnk.phy_reset     <= 1'b1;
      lnk.core_reset_tx <= 1'b1;
      lnk.core_reset_rx <= 1'b1;
      lnk.link_up       <= 1'b0;
      lnk.link_fail     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lock_cnt <= lock_nxt;
      retry_q  <= retry_nxt;
      {lnk.phy_reset, lnk.core_reset_tx, lnk.core_reset_rx, lnk.link_up, lnk.link_fail}
               <= decode(state_nxt);
    end
  end

  assign lnk.retry_cnt  = retry_q;
  assign lnk.ctrl_state = state;

endmodule

// File: tb/tb_xphy_link_ctrl.sv
// Bench for xphy_link_ctrl: run-length vector table checked through an expectation queue, plus timed bring-up sequences.
module tb_xphy_link_ctrl;

  logic clk156 = 1'b0;
  logic reset;

  xphy_link_ctrl_if lnk ();

  xphy_link_ctrl #(
    .C_RST_CYCLES   (4),
    .C_WAIT_TIMEOUT (16),
    .C_LOCK_DEBOUNCE(8),
    .C_RETRY_MAX    (2)
  ) dut (
    .clk156(clk156),
    .reset (reset),
    .lnk   (lnk)
  );

  initial forever #5 clk156 = ~clk156;

  // Stimulus bits: {reset, tx_resetdone, rx_resetdone, signal_detect, tx_fault, block_lock, restart}
  localparam logic [6:0] RST    = 7'b1_11_1_0_1_0;
  localparam logic [6:0] OK     = 7'b0_11_1_0_1_0;
  localparam logic [6:0] NOLOCK = 7'b0_11_1_0_0_0;
  localparam logic [6:0] NOSIG  = 7'b0_11_0_0_1_0;
  localparam logic [6:0] FLT    = 7'b0_11_1_1_1_0;
  localparam logic [6:0] NOTX   = 7'b0_01_1_0_1_0;
  localparam logic [6:0] TXSIG  = 7'b0_01_0_0_1_0;
  localparam logic [6:0] NORX   = 7'b0_10_1_0_1_0;
  localparam logic [6:0] RSTRT  = 7'b0_11_1_0_1_1;

  // Expected {phy_reset, core_reset_tx, core_reset_rx}
  localparam logic [2:0] R_H = 3'b111;
  localparam logic [2:0] R_D = 3'b011;
  localparam logic [2:0] R_T = 3'b001;
  localparam logic [2:0] R_L = 3'b000;

  localparam logic [2:0] S_HOLD = 3'd0, S_WDONE = 3'd1, S_WSIG = 3'd2, S_REL = 3'd3,
                         S_WLOCK = 3'd4, S_UP = 3'd5, S_FAIL = 3'd6;

  typedef struct {
    int         n;
    logic [6:0] stim;
    logic [2:0] st;
    logic [2:0] rsts;
    logic       up;
    logic       fail;
    logic [7:0] rty;
  } vec_t;

  typedef struct {
    int         row;
    logic [2:0] st;
    logic [2:0] rsts;
    logic       up;
    logic       fail;
    logic [7:0] rty;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int n, logic [6:0] stim, logic [2:0] st, logic [2:0] rsts,
                              logic up, logic fail, logic [7:0] rty);
    vec_t v;
    v.n = n; v.stim = stim; v.st = st; v.rsts = rsts; v.up = up; v.fail = fail; v.rty = rty;
    return v;
  endfunction

  task automatic drive(input logic [6:0] stim);
    {reset, lnk.tx_resetdone, lnk.rx_resetdone, lnk.signal_detect,
     lnk.tx_fault, lnk.block_lock, lnk.restart} = stim;
  endtask

  task automatic tick(input logic [6:0] stim);
    drive(stim);
    @(posedge clk156);
    #1;
  endtask

  task automatic check_out();
    exp_t e;
    logic [2:0] got_r;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue, want one entry");
      return;
    end
    e = sb.pop_front();
    got_r = {lnk.phy_reset, lnk.core_reset_tx, lnk.core_reset_rx};
    checks++;
    if (lnk.ctrl_state !== e.st || got_r !== e.rsts || lnk.link_up !== e.up ||
        lnk.link_fail !== e.fail || lnk.retry_cnt !== e.rty) begin
      errors++;
      $display("FAIL row%0d: got st=%0d rst=%b up=%b fail=%b retry=%0d, want st=%0d rst=%b up=%b fail=%b retry=%0d",
               e.row, lnk.ctrl_state, got_r, lnk.link_up, lnk.link_fail, lnk.retry_cnt,
               e.st, e.rsts, e.up, e.fail, e.rty);
    end
  endtask

  task automatic run_row(input int idx, input vec_t v);
    exp_t e;
    drive(v.stim);
    repeat (v.n - 1) begin
      @(posedge clk156);
      #1;
    end
    e.row = idx; e.st = v.st; e.rsts = v.rsts; e.up = v.up; e.fail = v.fail; e.rty = v.rty;
    sb.push_back(e);
    @(posedge clk156);
    #1;
    check_out();
  endtask

  // Counts clock edges from reset release until link_up, optionally dropping lock once at debounce count 5.
  task automatic timed_bringup(input bit glitch, output int steps);
    steps = 0;
    tick(RST);
    tick(RST);
    while (lnk.ctrl_state !== S_WLOCK && steps < 100) begin
      tick(OK);
      steps++;
    end
    if (glitch) begin
      repeat (5) begin tick(OK); steps++; end
      tick(NOLOCK);
      steps++;
    end
    while (lnk.link_up !== 1'b1 && steps < 100) begin
      tick(OK);
      steps++;
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int t_clean, t_glitch;
    drive(RST);

    // Clean bring-up and reset values
    tbl.push_back(mk(2,  RST,    S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(3,  OK,     S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WDONE, R_D, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_REL,   R_T, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(7,  OK,     S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_UP,    R_L, 1, 0, 0));
    // Single-cycle lock drop in UP relocks without a PHY reset pulse
    tbl.push_back(mk(1,  NOLOCK, S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_REL,   R_T, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(7,  OK,     S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_UP,    R_L, 1, 0, 0));
    tbl.push_back(mk(20, OK,     S_UP,    R_L, 1, 0, 0));
    // tx_fault in UP, fibre loss in REL_TX / WAIT_LOCK, no timeout in WAIT_SIG
    tbl.push_back(mk(1,  FLT,    S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(5,  FLT,    S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_REL,   R_T, 0, 0, 0));
    tbl.push_back(mk(1,  NOSIG,  S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(40, NOSIG,  S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_REL,   R_T, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(1,  NOSIG,  S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(2,  OK,     S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(7,  OK,     S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_UP,    R_L, 1, 0, 0));
    // Resetdone loss together with signal loss in UP: full re-sequence
    tbl.push_back(mk(1,  TXSIG,  S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(3,  OK,     S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WDONE, R_D, 0, 0, 0));
    tbl.push_back(mk(3,  OK,     S_WLOCK, R_L, 0, 0, 0));
    // One-cycle reset in WAIT_LOCK
    tbl.push_back(mk(1,  RST,    S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(3,  OK,     S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WDONE, R_D, 0, 0, 0));
    // Resetdone loss in WAIT_SIG
    tbl.push_back(mk(1,  NOSIG,  S_WSIG,  R_D, 0, 0, 0));
    tbl.push_back(mk(1,  NOTX,   S_HOLD,  R_H, 0, 0, 0));
    // WAIT_LOCK timeout counts a retry; reaching UP clears it
    tbl.push_back(mk(3,  OK,     S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(3,  OK,     S_REL,   R_T, 0, 0, 0));
    tbl.push_back(mk(1,  NOLOCK, S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(15, NOLOCK, S_WLOCK, R_L, 0, 0, 0));
    tbl.push_back(mk(1,  NOLOCK, S_HOLD,  R_H, 0, 0, 1));
    tbl.push_back(mk(3,  OK,     S_HOLD,  R_H, 0, 0, 1));
    tbl.push_back(mk(4,  OK,     S_WLOCK, R_L, 0, 0, 1));
    tbl.push_back(mk(7,  OK,     S_WLOCK, R_L, 0, 0, 1));
    tbl.push_back(mk(1,  OK,     S_UP,    R_L, 1, 0, 0));
    // rx_resetdone never rises: two timeouts, FAIL, then restart
    tbl.push_back(mk(1,  RST,    S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(4,  NORX,   S_WDONE, R_D, 0, 0, 0));
    tbl.push_back(mk(15, NORX,   S_WDONE, R_D, 0, 0, 0));
    tbl.push_back(mk(1,  NORX,   S_HOLD,  R_H, 0, 0, 1));
    tbl.push_back(mk(3,  NORX,   S_HOLD,  R_H, 0, 0, 1));
    tbl.push_back(mk(1,  NORX,   S_WDONE, R_D, 0, 0, 1));
    tbl.push_back(mk(15, NORX,   S_WDONE, R_D, 0, 0, 1));
    tbl.push_back(mk(1,  NORX,   S_FAIL,  R_H, 0, 1, 2));
    tbl.push_back(mk(10, NORX,   S_FAIL,  R_H, 0, 1, 2));
    tbl.push_back(mk(5,  OK,     S_FAIL,  R_H, 0, 1, 2));
    tbl.push_back(mk(1,  RSTRT,  S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(3,  OK,     S_HOLD,  R_H, 0, 0, 0));
    tbl.push_back(mk(1,  OK,     S_WDONE, R_D, 0, 0, 0));

    foreach (tbl[i]) run_row(i, tbl[i]);

    // Debounce restart: link_up comes 6 edges later when lock drops at count 5
    timed_bringup(1'b0, t_clean);
    check_int("clean_bringup_edges", t_clean, 15);
    timed_bringup(1'b1, t_glitch);
    check_int("glitch_bringup_edges", t_glitch, 21);
    check_int("glitch_delay", t_glitch - t_clean, 6);
    check_int("up_retry_cnt", int'(lnk.retry_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
